load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  MEM-stage load/store unit between the EX/MEM pipeline register and data_memory.
//  Turns LB/LBU/LH/LHU/LW/SB/SH/SW requests into word-wide data_memory accesses.
//  Sub-word stores use a 2-cycle read-modify-write; loads are sign- or zero-extended.
//  Asserts stall to freeze the upstream pipeline for the access's first cycle.
// PARAMETERS
//  ADDR_W  32  byte-address width; data path is fixed at 32 bits
// PORTS
//  clk           in   1       single clock, rising edge
//  rst_n         in   1       asynchronous, active-low reset
//  req           in   1       access request, held by the pipeline while stall=1
//  we            in   1       1=store, 0=load
//  size          in   2       00 byte, 01 half, 10 word, 11 treated as word
//  unsigned_ld   in   1       1=zero-extend load (LBU/LHU), 0=sign-extend
//  addr          in   ADDR_W  byte address
//  wdata         in   32      store data, right-justified
//  stall         out  1       hold upstream this cycle
//  rdata_valid   out  1       load result valid this cycle
//  rdata         out  32      extended load result, 0 when rdata_valid=0
//  misalign      out  1       misaligned-access flag (see CONFIGURATION)
//  m_write       out  1       data_memory write strobe
//  m_read        out  1       data_memory read strobe
//  m_addrs       out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
//  m_in          out  32      data_memory write data
//  m_out         in   32      data_memory read data, valid the cycle after m_read
// BEHAVIOUR
//  - data_memory writes on posedge when m_write=1; read data appears 1 cycle after m_read.
//  - FSM states: IDLE, LD_RESP, RMW_MERGE. Reset -> IDLE; all outputs 0.
//  - IDLE, no req: all outputs 0.
//  - IDLE, word store: m_write=1, m_in=wdata, stall=0. Single cycle; stay in IDLE.
//  - IDLE, load: m_read=1, stall=1. Latch size, unsigned_ld and addr[1:0]. Go to LD_RESP.
//  - LD_RESP: stall=0, rdata_valid=1; rdata=extract(m_out); next state IDLE.
//    The held req is ignored in this state. Load latency is 1 stall cycle.
//  - IDLE, byte/half store: m_read=1, stall=1. Latch addr, size and wdata. Go to RMW_MERGE.
//  - RMW_MERGE: m_write=1, m_addrs=latched address, stall=0; next state IDLE.
//    m_in = m_out with the target lane(s) replaced by wdata[7:0] or wdata[15:0].
//  - Lanes are little-endian: byte k (addr[1:0]=k) occupies bits [8k+7:8k].
//    The half at addr[1] occupies bits [16*addr[1]+15 : 16*addr[1]].
//  - Extract: select the lane, then sign- or zero-extend to 32 bits; word passes through.
//  - The next request is accepted only in IDLE, so back-to-back accesses cost 1 or 2 cycles.
//  - Async reset mid-RMW: FSM goes to IDLE immediately and no write is issued.
//    The memory word is left unchanged.
//  - Async reset during LD_RESP: rdata_valid drops to 0 at once.
// CONFIGURATION
//  `LSU_MISALIGN_TRAP_EN defined:
//   - Misaligned means a half with addr[0]=1, or a word with addr[1:0]!=0.
//   - A misaligned req in IDLE gives misalign=1 for that cycle, with stall=0 and no m_read/m_write.
//   - The FSM stays in IDLE.
//  `LSU_MISALIGN_TRAP_EN undefined:
//   - misalign is tied 0. addr[0] is ignored for halves; addr[1:0] is ignored for words.
// STRUCTURE
//  - Package mips_mem_pkg holds: size encodings SZ_BYTE/SZ_HALF/SZ_WORD; FSM state typedef/localparams.
//  - Sub-module lsu_lane_align (combinational) holds the store-lane merge and load extract/extend.
//    It is shared by the merge path and the extract path.
// TESTING  (bench pairs the block with data_memory)
//  - SW 0x11223344 @0x8, then LW @0x8 -> no stall on SW. LW gives 1 stall cycle, then rdata=0x11223344.
//  - Then SB 0xAA @0xA -> 1 stall cycle, m_write in RMW_MERGE with m_in=0x11AA3344.
//    A following LW @0x8 returns 0x11AA3344.
//  - LB @0xA -> rdata=0xFFFFFFAA. LBU @0xA -> rdata=0x000000AA.
//  - SH 0x8001 @0x8 over 0x11AA3344 -> word 0x11AA8001.
//    LH @0x8 -> 0xFFFF8001; LHU @0x8 -> 0x00008001.
//  - LW @0x9 with `LSU_MISALIGN_TRAP_EN -> misalign=1 for 1 cycle, no m_read, stall=0.
//    Without the macro -> reads 0x8 and returns 0x11AA8001.
//  - SB 0x55 @0xB, rst_n low during RMW_MERGE -> no write. LW @0x8 after reset -> 0x11AA8001.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access sizes, FSM states,
// data path widths and the alignment check used when misalign trapping is built in.
package mips_mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 2;

    localparam logic [SIZE_W-1:0] SZ_BYTE = 2'b00;
    localparam logic [SIZE_W-1:0] SZ_HALF = 2'b01;
    localparam logic [SIZE_W-1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LD_RESP   = 2'd1,
        RMW_MERGE = 2'd2
    } lsu_state_t;

    // Size 2'b11 is treated as a word, so only bit 1 matters for "word".
    function automatic logic is_word(input logic [SIZE_W-1:0] size);
        return size[1];
    endfunction

    // Half with odd byte offset, or word not on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [SIZE_W-1:0] size,
                                           input logic [1:0]        offset);
        if (is_word(size))
            return offset != 2'b00;
        else if (size == SZ_HALF)
            return offset[0];
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane logic: merges store data into a fetched word and extracts /
// extends a load result from a fetched word. Purely combinational.
module lsu_lane_align
    import mips_mem_pkg::*;
(
    input  logic [SIZE_W-1:0] size,
    input  logic [1:0]        offset,
    input  logic              unsigned_ld,
    input  logic [DATA_W-1:0] mem_word,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] merged_c,
    output logic [DATA_W-1:0] extracted_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and half out of the memory word.
    always_comb begin
        case (offset)
            2'd0:    byte_sel = mem_word[7:0];
            2'd1:    byte_sel = mem_word[15:8];
            2'd2:    byte_sel = mem_word[23:16];
            default: byte_sel = mem_word[31:24];
        endcase
        half_sel = offset[1] ? mem_word[31:16] : mem_word[15:0];
    end

    // Load result: sign- or zero-extend the selected lane; words pass through.
    always_comb begin
        if (is_word(size))
            extracted_c = mem_word;
        else if (size[0])
            extracted_c = unsigned_ld ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
        else
            extracted_c = unsigned_ld ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
    end

    // Store merge: replace only the target lane(s) of the fetched word.
    always_comb begin
        merged_c = mem_word;
        if (is_word(size)) begin
            merged_c = wdata;
        end else if (size[0]) begin
            if (offset[1])
                merged_c[31:16] = wdata[15:0];
            else
                merged_c[15:0]  = wdata[15:0];
        end else begin
            case (offset)
                2'd0:    merged_c[7:0]   = wdata[7:0];
                2'd1:    merged_c[15:8]  = wdata[7:0];
                2'd2:    merged_c[23:16] = wdata[7:0];
                default: merged_c[31:24] = wdata[7:0];
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit. Word stores take one cycle; loads and sub-word stores
// read first (stalling upstream for that cycle) and finish in the following cycle.
// Build option: LSU_MISALIGN_TRAP_EN flags misaligned halves/words instead of
// silently aligning them down.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              rdata_valid,
    output logic [31:0]       rdata,
    output logic              misalign,
    output logic              m_write,
    output logic              m_read,
    output logic [ADDR_W-1:0] m_addrs,
    output logic [31:0]       m_in,
    input  logic [31:0]       m_out
);

    lsu_state_t          state_q, state_d;
    logic [ADDR_W-3:0]   waddr_q;
    logic [SIZE_W-1:0]   size_q;
    logic [1:0]          off_q;
    logic                uns_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   merged_c;
    logic [DATA_W-1:0]   extracted_c;
    logic                mis_c;
    logic                two_cycle_c;

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis_c = is_misaligned(size, addr[1:0]);
`else
    assign mis_c = 1'b0;
`endif

    // Loads and sub-word stores need a read cycle before they complete.
    assign two_cycle_c = !(we && is_word(size));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Capture the access context when a two-cycle access is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_q <= '0;
            size_q  <= '0;
            off_q   <= '0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
        end else if (state_q == IDLE && req && !mis_c && two_cycle_c) begin
            waddr_q <= addr[ADDR_W-1:2];
            size_q  <= size;
            off_q   <= addr[1:0];
            uns_q   <= unsigned_ld;
            wdata_q <= wdata;
        end
    end

    // Next-state logic; requests are only accepted in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req && !mis_c && two_cycle_c)
                    state_d = we ? RMW_MERGE : LD_RESP;
            end
            LD_RESP:   state_d = IDLE;
            RMW_MERGE: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    lsu_lane_align u_lane_align (
        .size        (size_q),
        .offset      (off_q),
        .unsigned_ld (uns_q),
        .mem_word    (m_out),
        .wdata       (wdata_q),
        .merged_c    (merged_c),
        .extracted_c (extracted_c)
    );

    // Output decode; everything is held at 0 while reset is asserted so an
    // interrupted read-modify-write never reaches memory.
    always_comb begin
        stall       = 1'b0;
        rdata_valid = 1'b0;
        rdata       = '0;
        misalign    = 1'b0;
        m_write     = 1'b0;
        m_read      = 1'b0;
        m_addrs     = '0;
        m_in        = '0;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (mis_c) begin
                            misalign = 1'b1;
                        end else begin
                            m_addrs = {addr[ADDR_W-1:2], 2'b00};
                            if (two_cycle_c) begin
                                m_read = 1'b1;
                                stall  = 1'b1;
                            end else begin
                                m_write = 1'b1;
                                m_in    = wdata;
                            end
                        end
                    end
                end
                LD_RESP: begin
                    rdata_valid = 1'b1;
                    rdata       = extracted_c;
                end
                RMW_MERGE: begin
                    m_write = 1'b1;
                    m_addrs = {waddr_q, 2'b00};
                    m_in    = merged_c;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit paired with a small word-wide data memory.
module tb_load_store_unit;
    import mips_mem_pkg::*;

    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              unsigned_ld;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              stall;
    logic              rdata_valid;
    logic [31:0]       rdata;
    logic              misalign;
    logic              m_write;
    logic              m_read;
    logic [ADDR_W-1:0] m_addrs;
    logic [31:0]       m_in;
    logic [31:0]       m_out;

    logic [31:0] mem [0:15];

    int checks = 0;
    int errors = 0;

    // First-cycle and second-cycle observations filled by the drivers.
    logic        o1_stall, o1_read, o1_write, o1_mis;
    logic [31:0] o1_in, o1_addr;
    logic        o2_stall, o2_read, o2_write, o2_valid;
    logic [31:0] o2_in, o2_addr, o2_rdata;
    logic        o3_valid;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .we          (we),
        .size        (size),
        .unsigned_ld (unsigned_ld),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata_valid (rdata_valid),
        .rdata       (rdata),
        .misalign    (misalign),
        .m_write     (m_write),
        .m_read      (m_read),
        .m_addrs     (m_addrs),
        .m_in        (m_in),
        .m_out       (m_out)
    );

    always #5 clk = ~clk;

    // data_memory: write on posedge, read data one cycle after m_read.
    always @(posedge clk) begin
        if (m_write) mem[m_addrs[5:2]] <= m_in;
        if (m_read)  m_out <= mem[m_addrs[5:2]];
    end

    task automatic idle_inputs();
        req = 1'b0; we = 1'b0; size = SZ_WORD; unsigned_ld = 1'b0; addr = '0; wdata = '0;
    endtask

    // Drive one store; sub-word stores keep req held through RMW_MERGE.
    task automatic run_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = sz; unsigned_ld = 1'b0; addr = a; wdata = wd;
        #1;
        o1_stall = stall; o1_read = m_read; o1_write = m_write; o1_in = m_in;
        o1_addr = m_addrs; o1_mis = misalign;
        @(negedge clk);
        if (sz[1]) req = 1'b0;
        #1;
        o2_stall = stall; o2_read = m_read; o2_write = m_write; o2_in = m_in; o2_addr = m_addrs;
        @(negedge clk);
        idle_inputs();
    endtask

    // Drive one load; req stays held during LD_RESP, then drops.
    task automatic run_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = sz; unsigned_ld = uns; addr = a; wdata = 32'hFFFF_FFFF;
        #1;
        o1_stall = stall; o1_read = m_read; o1_write = m_write; o1_addr = m_addrs;
        o1_mis = misalign;
        @(negedge clk);
        #1;
        o2_stall = stall; o2_read = m_read; o2_valid = rdata_valid; o2_rdata = rdata;
        @(negedge clk);
        idle_inputs();
        #1;
        o3_valid = rdata_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        req = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({stall, rdata_valid, misalign, m_write, m_read} !== 5'b0 || m_in !== 32'h0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got ctl=%b m_in=%h rdata=%h exp all 0",
                     {stall, rdata_valid, misalign, m_write, m_read}, m_in, rdata);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        #1;
        checks++;
        if ({stall, rdata_valid, m_write, m_read} !== 4'b0) begin
            errors++;
            $display("FAIL idle_no_req got %b exp 0000", {stall, rdata_valid, m_write, m_read});
        end
    endtask

    task automatic test_word();
        run_store(32'h8, SZ_WORD, 32'h1122_3344);
        checks++;
        if ({o1_stall, o1_read, o1_write} !== 3'b001 || o1_in !== 32'h1122_3344 || o1_addr !== 32'h8) begin
            errors++;
            $display("FAIL sw_cycle got stall/rd/wr=%b m_in=%h addr=%h exp 001 11223344 00000008",
                     {o1_stall, o1_read, o1_write}, o1_in, o1_addr);
        end
        checks++;
        if (o2_write !== 1'b0) begin
            errors++; $display("FAIL sw_single_cycle got m_write=%b exp 0", o2_write);
        end
        run_load(32'h8, SZ_WORD, 1'b0);
        checks++;
        if ({o1_stall, o1_read, o1_write} !== 3'b110 || o1_addr !== 32'h8) begin
            errors++;
            $display("FAIL lw_first got stall/rd/wr=%b addr=%h exp 110 00000008", {o1_stall, o1_read, o1_write}, o1_addr);
        end
        checks++;
        if ({o2_stall, o2_read, o2_valid} !== 3'b001 || o2_rdata !== 32'h1122_3344) begin
            errors++;
            $display("FAIL lw_resp got stall/rd/valid=%b rdata=%h exp 001 11223344", {o2_stall, o2_read, o2_valid}, o2_rdata);
        end
        checks++;
        if (o3_valid !== 1'b0) begin
            errors++; $display("FAIL lw_valid_drop got %b exp 0", o3_valid);
        end
    endtask

    task automatic test_byte();
        run_store(32'hA, SZ_BYTE, 32'hDEAD_BEAA);
        checks++;
        if ({o1_stall, o1_read, o1_write} !== 3'b110) begin
            errors++; $display("FAIL sb_first got stall/rd/wr=%b exp 110", {o1_stall, o1_read, o1_write});
        end
        checks++;
        if ({o2_stall, o2_write} !== 2'b01 || o2_in !== 32'h11AA_3344 || o2_addr !== 32'h8) begin
            errors++;
            $display("FAIL sb_merge got stall/wr=%b m_in=%h addr=%h exp 01 11AA3344 00000008",
                     {o2_stall, o2_write}, o2_in, o2_addr);
        end
        run_load(32'h8, SZ_WORD, 1'b0);
        checks++;
        if (o2_rdata !== 32'h11AA_3344) begin
            errors++; $display("FAIL sb_readback got %h exp 11AA3344", o2_rdata);
        end
        run_load(32'hA, SZ_BYTE, 1'b0);
        checks++;
        if (o2_valid !== 1'b1 || o2_rdata !== 32'hFFFF_FFAA) begin
            errors++; $display("FAIL lb got valid=%b rdata=%h exp 1 FFFFFFAA", o2_valid, o2_rdata);
        end
        run_load(32'hA, SZ_BYTE, 1'b1);
        checks++;
        if (o2_rdata !== 32'h0000_00AA) begin
            errors++; $display("FAIL lbu got %h exp 000000AA", o2_rdata);
        end
        run_load(32'hB, SZ_BYTE, 1'b0);
        checks++;
        if (o2_rdata !== 32'h0000_0011) begin
            errors++; $display("FAIL lb_lane3 got %h exp 00000011", o2_rdata);
        end
    endtask

    task automatic test_half();
        run_store(32'h8, SZ_HALF, 32'hCAFE_8001);
        checks++;
        if (o2_write !== 1'b1 || o2_in !== 32'h11AA_8001) begin
            errors++; $display("FAIL sh_merge got wr=%b m_in=%h exp 1 11AA8001", o2_write, o2_in);
        end
        run_load(32'h8, SZ_HALF, 1'b0);
        checks++;
        if (o2_rdata !== 32'hFFFF_8001) begin
            errors++; $display("FAIL lh got %h exp FFFF8001", o2_rdata);
        end
        run_load(32'h8, SZ_HALF, 1'b1);
        checks++;
        if (o2_rdata !== 32'h0000_8001) begin
            errors++; $display("FAIL lhu got %h exp 00008001", o2_rdata);
        end
        run_load(32'hA, SZ_HALF, 1'b0);
        checks++;
        if (o2_rdata !== 32'h0000_11AA) begin
            errors++; $display("FAIL lh_upper got %h exp 000011AA", o2_rdata);
        end
        run_load(32'h8, 2'b11, 1'b0);
        checks++;
        if (o2_rdata !== 32'h11AA_8001) begin
            errors++; $display("FAIL size11_word got %h exp 11AA8001", o2_rdata);
        end
    endtask

    task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = SZ_WORD; unsigned_ld = 1'b0; addr = 32'h9;
        #1;
        checks++;
        if ({misalign, stall, m_read, m_write} !== 4'b1000) begin
            errors++; $display("FAIL lw_misaligned got mis/stall/rd/wr=%b exp 1000", {misalign, stall, m_read, m_write});
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if ({misalign, rdata_valid} !== 2'b00) begin
            errors++; $display("FAIL misalign_one_cycle got mis/valid=%b exp 00", {misalign, rdata_valid});
        end
`else
        run_load(32'h9, SZ_WORD, 1'b0);
        checks++;
        if (o1_mis !== 1'b0 || o1_addr !== 32'h8 || o1_stall !== 1'b1) begin
            errors++; $display("FAIL lw_unaligned_addr got mis=%b addr=%h stall=%b exp 0 00000008 1", o1_mis, o1_addr, o1_stall);
        end
        checks++;
        if (o2_rdata !== 32'h11AA_8001) begin
            errors++; $display("FAIL lw_unaligned_data got %h exp 11AA8001", o2_rdata);
        end
`endif
    endtask

    task automatic test_reset_mid_access();
        // Reset during RMW_MERGE of SB 0x55 @0xB must not write.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = SZ_BYTE; addr = 32'hB; wdata = 32'h0000_0055;
        @(negedge clk);
        #1;
        checks++;
        if (m_write !== 1'b1 || m_in !== 32'h55AA_8001) begin
            errors++; $display("FAIL sb_pre_reset got wr=%b m_in=%h exp 1 55AA8001", m_write, m_in);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_write, stall, m_read} !== 3'b000) begin
            errors++; $display("FAIL rmw_reset got wr/stall/rd=%b exp 000", {m_write, stall, m_read});
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        run_load(32'h8, SZ_WORD, 1'b0);
        checks++;
        if (o2_rdata !== 32'h11AA_8001) begin
            errors++; $display("FAIL rmw_reset_mem got %h exp 11AA8001", o2_rdata);
        end
        // Reset during LD_RESP drops rdata_valid at once.
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = SZ_WORD; addr = 32'h8;
        @(negedge clk);
        #1;
        checks++;
        if (rdata_valid !== 1'b1) begin
            errors++; $display("FAIL ld_resp_pre_reset got %b exp 1", rdata_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rdata_valid !== 1'b0 || rdata !== 32'h0) begin
            errors++; $display("FAIL ld_resp_reset got valid=%b rdata=%h exp 0 00000000", rdata_valid, rdata);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        m_out = 32'h0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misalign();
        test_reset_mid_access();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
